// File: rtl/bus_interface.sv
// bus_interface
// Converts the 6502 core's per-cycle accesses into an external memory
// request/acknowledge bus with wait states. Writes are posted into a small
// circular write buffer. Reads stall the core until memory returns data. A
// watchdog aborts any transaction whose request stays unacknowledged for
// TIMEOUT cycles and raises a sticky error.
//
// Ports:
//   ph1            in   sole clock, rising edge
//   reset          in   asynchronous active-low reset
//   core_valid     in   core presents an access this cycle
//   core_read_en   in   1 = read, 0 = write
//   core_address   in   [15:0] access address
//   core_data_out  in   [7:0]  write data from the core
//   core_data_in   out  [7:0]  read data to the core (registered, held)
//   core_stall     out  core must hold its request (combinational)
//   mem_req        out  external request, held until acknowledged
//   mem_we         out  1 = write transaction
//   mem_addr       out  [15:0] transaction address
//   mem_wdata      out  [7:0]  transaction write data
//   mem_ack        in   memory completed the transaction this cycle
//   mem_rdata      in   [7:0]  read data, valid with mem_ack
//   err_clr        in   synchronous clear of bus_error
//   bus_error      out  sticky timeout flag
//   wb_empty       out  write buffer holds no entries (combinational)
module bus_interface #(
  parameter int WB_DEPTH = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        core_valid,
  input  logic        core_read_en,
  input  logic [15:0] core_address,
  input  logic [7:0]  core_data_out,
  output logic [7:0]  core_data_in,
  output logic        core_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        err_clr,
  output logic        bus_error,
  output logic        wb_empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RDONE = 2'd3
  } state_t;

  localparam logic [2:0] DEPTH_C  = 3'(WB_DEPTH);
  localparam logic [1:0] LAST_PTR = 2'(WB_DEPTH - 1);
  // Abort fires in the request cycle whose count would reach TIMEOUT.
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  core_data_in_q, core_data_in_d;
  logic        bus_error_q, bus_error_d;

  // Buffer storage is sized for the largest legal depth so a 2-bit pointer
  // indexes it exactly; only the first WB_DEPTH slots are ever used.
  logic [15:0] wb_addr_q [4];
  logic [7:0]  wb_data_q [4];

  logic        wb_full;
  logic        enq;
  logic        deq;
  logic        ack_seen;
  logic        timeout_hit;
  logic [15:0] head_addr;
  logic [7:0]  head_data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Full is taken from registered count only, so a slot freed by an ack in
  // this cycle cannot accept a write until the following cycle.
  assign wb_full     = (count_q == DEPTH_C);
  assign wb_empty    = (count_q == 3'd0);
  assign enq         = core_valid && !core_read_en && !wb_full;
  assign ack_seen    = mem_req_q && mem_ack;
  assign timeout_hit = mem_req_q && !mem_ack && (tcnt_q == TO_LAST);
  assign head_addr   = wb_addr_q[head_q];
  assign head_data   = wb_data_q[head_q];

  assign core_stall  = core_valid && (core_read_en ? (state_q != RDONE) : wb_full);

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_data_in = core_data_in_q;
  assign bus_error    = bus_error_q;

  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    core_data_in_d = core_data_in_q;
    bus_error_d    = bus_error_q;
    tcnt_d         = 8'd0;
    deq            = 1'b0;

    if (err_clr) begin
      bus_error_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (count_q != 3'd0) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
          state_d     = WRITE;
        end else if (enq) begin
          // Empty buffer: the write being enqueued right now becomes the
          // head, so it goes straight onto the bus for one-cycle latency.
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = core_address;
          mem_wdata_d = core_data_out;
          state_d     = WRITE;
        end else if (core_valid && core_read_en) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = core_address;
          state_d    = READ;
        end
      end

      WRITE: begin
        if (ack_seen) begin
          deq       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          // Hung write is discarded; a timeout outranks err_clr.
          deq         = 1'b1;
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      READ: begin
        if (ack_seen) begin
          core_data_in_d = mem_rdata;
          mem_req_d      = 1'b0;
          state_d        = RDONE;
        end else if (timeout_hit) begin
          core_data_in_d = 8'hFF;
          mem_req_d      = 1'b0;
          bus_error_d    = 1'b1;
          state_d        = RDONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      RDONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    head_d  = deq ? ptr_inc(head_q) : head_q;
    tail_d  = enq ? ptr_inc(tail_q) : tail_q;
    count_d = count_q + 3'(enq) - 3'(deq);
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      head_q         <= 2'd0;
      tail_q         <= 2'd0;
      count_q        <= 3'd0;
      tcnt_q         <= 8'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 16'h0000;
      mem_wdata_q    <= 8'h00;
      core_data_in_q <= 8'h00;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      tcnt_q         <= tcnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      core_data_in_q <= core_data_in_d;
      bus_error_q    <= bus_error_d;
    end
  end

  // Entry storage needs no reset: validity is carried by count/pointers.
  always_ff @(posedge ph1) begin
    if (enq) begin
      wb_addr_q[tail_q] <= core_address;
      wb_data_q[tail_q] <= core_data_out;
    end
  end

endmodule

// File: tb/tb_bus_interface.sv
module tb_bus_interface;

  localparam int DEPTH = 2;
  localparam int TMO   = 8;

  logic        ph1 = 1'b0;
  logic        reset = 1'b0;
  logic        core_valid = 1'b0;
  logic        core_read_en = 1'b0;
  logic [15:0] core_address = 16'h0000;
  logic [7:0]  core_data_out = 8'h00;
  logic [7:0]  core_data_in;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        err_clr = 1'b0;
  logic        bus_error;
  logic        wb_empty;

  int total = 0;
  int bad   = 0;

  bus_interface #(.WB_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .ph1          (ph1),
    .reset        (reset),
    .core_valid   (core_valid),
    .core_read_en (core_read_en),
    .core_address (core_address),
    .core_data_out(core_data_out),
    .core_data_in (core_data_in),
    .core_stall   (core_stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .err_clr      (err_clr),
    .bus_error    (bus_error),
    .wb_empty     (wb_empty)
  );

  always #5 ph1 = ~ph1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- memory responder ----------------
  int          lat_mode = 1;
  int          lat_fix  = 0;
  int          lat_cur  = 0;
  int          wcnt     = 0;
  bit          rdata_fix_en = 1'b0;
  logic [7:0]  rdata_fix = 8'h00;
  bit          err_rand = 1'b0;
  logic        err_force = 1'b0;

  always @(posedge ph1) begin
    #2;
    if (mem_req) begin
      mem_ack = (wcnt >= lat_cur);
      wcnt++;
    end else begin
      wcnt = 0;
      if (lat_mode != 0) lat_cur = lat_fix;
      else lat_cur = ($urandom_range(0, 15) == 0) ? 12 : int'($urandom_range(0, 4));
      mem_ack = 1'($urandom_range(0, 1));
    end
    mem_rdata = rdata_fix_en ? rdata_fix : 8'($urandom);
    err_clr   = err_rand ? ($urandom_range(0, 15) == 0) : err_force;
  end

  // ---------------- transaction log ----------------
  typedef struct packed {logic we; logic [15:0] a; logic [7:0] d;} txn_t;
  txn_t log_q[$];

  always @(negedge ph1) begin
    if (reset && mem_req && mem_ack) log_q.push_back({mem_we, mem_addr, mem_wdata});
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
  wr_t         mq[$];
  bit          m_busy, m_we, m_rdone, m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  int          m_age;

  function automatic void model_reset();
    mq.delete();
    m_busy = 0; m_we = 0; m_rdone = 0; m_err = 0;
    m_addr = 16'h0000; m_wdata = 8'h00; m_rdata = 8'h00; m_age = 0;
  endfunction

  function automatic void model_compare();
    bit exp_stall;
    exp_stall = core_valid && (core_read_en ? !m_rdone : (mq.size() == DEPTH));
    chk("m_mem_req", 32'(mem_req), 32'(m_busy));
    chk("m_mem_we", 32'(mem_we), 32'(m_we));
    chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("m_core_data_in", 32'(core_data_in), 32'(m_rdata));
    chk("m_bus_error", 32'(bus_error), 32'(m_err));
    chk("m_wb_empty", 32'(wb_empty), 32'(mq.size() == 0));
    chk("m_core_stall", 32'(core_stall), 32'(exp_stall));
  endfunction

  // Advance the model across the coming rising edge using the inputs now held.
  function automatic void model_step();
    bit acc_w, busy_n, rdone_n, err_n;
    acc_w   = core_valid && !core_read_en && (mq.size() < DEPTH);
    busy_n  = m_busy;
    rdone_n = 0;
    err_n   = err_clr ? 1'b0 : m_err;
    if (m_busy) begin
      if (mem_ack) begin
        busy_n = 0; m_age = 0;
        if (m_we) void'(mq.pop_front());
        else begin m_rdata = mem_rdata; rdone_n = 1; end
      end else if (m_age + 1 == TMO) begin
        busy_n = 0; m_age = 0; err_n = 1;
        if (m_we) void'(mq.pop_front());
        else begin m_rdata = 8'hFF; rdone_n = 1; end
      end else begin
        m_age++;
      end
    end else if (!m_rdone) begin
      if (mq.size() > 0) begin
        busy_n = 1; m_we = 1; m_addr = mq[0].a; m_wdata = mq[0].d;
      end else if (acc_w) begin
        busy_n = 1; m_we = 1; m_addr = core_address; m_wdata = core_data_out;
      end else if (core_valid && core_read_en) begin
        busy_n = 1; m_we = 0; m_addr = core_address;
      end
    end
    if (acc_w) mq.push_back({core_address, core_data_out});
    m_busy = busy_n; m_rdone = rdone_n; m_err = err_n;
  endfunction

  always @(negedge ph1) begin
    if (!reset) model_reset();
    model_compare();
    if (reset) model_step();
  end

  // ---------------- core driver ----------------
  // Tasks start and end 1 time unit after a rising edge.
  task automatic access(input logic rd, input logic [15:0] a, input logic [7:0] d,
                        output int stalls, output logic [7:0] din);
    bit done;
    done = 0;
    core_valid = 1'b1; core_read_en = rd; core_address = a; core_data_out = d;
    stalls = 0; din = 8'h00;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge ph1);
      if (!core_stall) begin done = 1; din = core_data_in; end
      else stalls++;
      @(posedge ph1); #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_bound: addr %h still stalled after 200 cycles", a);
    end
    core_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge ph1); #1; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2, st3, n;
    logic [7:0] din;
    model_reset();
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(1);

    // Reset mid-write with two entries buffered, memory never acks.
    lat_mode = 1; lat_fix = 255;
    access(1'b0, 16'h0400, 8'hAA, st, din);
    access(1'b0, 16'h0401, 8'hBB, st2, din);
    chk("a_wr_nostall", 32'(st + st2), 32'd0);
    @(negedge ph1);
    chk("a_req_busy", 32'(mem_req), 32'd1);
    chk("a_wb_holds", 32'(wb_empty), 32'd0);
    @(posedge ph1); #1;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    @(negedge ph1);
    chk("a_req_after_rst", 32'(mem_req), 32'd0);
    chk("a_empty_after_rst", 32'(wb_empty), 32'd1);
    chk("a_err_after_rst", 32'(bus_error), 32'd0);
    n = 0;
    repeat (6) begin @(negedge ph1); if (mem_req) n++; end
    chk("a_no_activity", 32'(n), 32'd0);
    @(posedge ph1); #1;

    // Single read, ack in the first request cycle.
    lat_fix = 0; rdata_fix_en = 1; rdata_fix = 8'h5A; log_q.delete();
    access(1'b1, 16'h1234, 8'h00, st, din);
    chk("b_stalls", 32'(st), 32'd2);
    chk("b_data", 32'(din), 32'h5A);
    chk("b_ntxn", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) chk("b_txn", 32'({log_q[0].we, log_q[0].a}), 32'({1'b0, 16'h1234}));

    // Three back-to-back writes, three wait cycles each.
    lat_fix = 3; log_q.delete();
    access(1'b0, 16'h0200, 8'h11, st, din);
    access(1'b0, 16'h0201, 8'h22, st2, din);
    access(1'b0, 16'h0202, 8'h33, st3, din);
    chk("c_stall1", 32'(st), 32'd0);
    chk("c_stall2", 32'(st2), 32'd0);
    chk("c_stall3", 32'(st3), 32'd3);
    idle(20);
    chk("c_empty", 32'(wb_empty), 32'd1);
    chk("c_ntxn", 32'(log_q.size()), 32'd3);
    if (log_q.size() >= 3) begin
      chk("c_txn0", 32'(log_q[0]), 32'({1'b1, 16'h0200, 8'h11}));
      chk("c_txn1", 32'(log_q[1]), 32'({1'b1, 16'h0201, 8'h22}));
      chk("c_txn2", 32'(log_q[2]), 32'({1'b1, 16'h0202, 8'h33}));
    end

    // Write then immediate read of the same address: no forwarding.
    lat_fix = 1; rdata_fix = 8'hC3; log_q.delete();
    access(1'b0, 16'h0300, 8'h77, st, din);
    access(1'b1, 16'h0300, 8'h00, st2, din);
    chk("d_rd_stalls", 32'(st2), 32'd5);
    chk("d_rd_data", 32'(din), 32'hC3);
    chk("d_ntxn", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("d_txn0", 32'(log_q[0]), 32'({1'b1, 16'h0300, 8'h77}));
      chk("d_txn1", 32'({log_q[1].we, log_q[1].a}), 32'({1'b0, 16'h0300}));
    end
    idle(2);

    // Read timeout: eight request cycles, then 0xFF and sticky error.
    lat_fix = 255;
    access(1'b1, 16'h0ABC, 8'h00, st, din);
    chk("e_stalls", 32'(st), 32'd9);
    chk("e_data", 32'(din), 32'hFF);
    chk("e_err_set", 32'(bus_error), 32'd1);
    err_force = 1'b1;
    idle(1);
    err_force = 1'b0;
    chk("e_err_clr", 32'(bus_error), 32'd0);
    idle(2);

    // Write timeout in the same cycle as err_clr: error wins, entry dropped.
    log_q.delete();
    access(1'b0, 16'h0500, 8'h99, st, din);
    idle(7);
    err_force = 1'b1;
    idle(1);
    err_force = 1'b0;
    chk("f_err_kept", 32'(bus_error), 32'd1);
    chk("f_empty", 32'(wb_empty), 32'd1);
    chk("f_req_low", 32'(mem_req), 32'd0);
    chk("f_no_ack", 32'(log_q.size()), 32'd0);
    idle(2);

    // Randomised traffic against the model.
    lat_mode = 0; rdata_fix_en = 0; err_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
      end
      access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), st, din);
      idle(int'($urandom_range(0, 2)));
    end
    err_rand = 0;
    idle(40);
    chk("r_drained", 32'(wb_empty), 32'd1);
    chk("r_idle_req", 32'(mem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
